ahb5_protocol_checker: RTL and testbench

Synthesizable, parametrised AHB5 bus protocol checker. Successor to the immediate-assertion checker; it tracks burst state, beat counts, expected addresses, wait states and two-cycle error responses across cycles. Sits passively on the manager–interconnect link and snoops all address- and data-phase signals. Reports violations as registered pulses, sticky flags and a saturating counter, for the UVM scoreboard and for on-chip debug.

---
 rtl/ahb5_protocol_checker.sv | 199 +++++++++++++++++++
 tb/tb_ahb5_protocol_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb5_protocol_checker.sv
// AHB5 protocol checker: passive snoop of one manager link.
// Tracks bursts, beats, addresses, waits and error responses.
module ahb5_protocol_checker #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int HBURST_WIDTH = 3,
   parameter int NUM_SEL      = 1,
   parameter int MAX_WAIT     = 16,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic [NUM_SEL-1:0]      HSEL,
   input  logic                    HREADY,
   input  logic [ADDR_WIDTH-1:0]   HADDR,
   input  logic [HBURST_WIDTH-1:0] HBURST,
   input  logic [2:0]              HSIZE,
   input  logic [1:0]              HTRANS,
   input  logic                    HWRITE,
   input  logic                    HRESP,
   input  logic                    chk_en,
   input  logic                    clr,
   output logic [8:0]              viol_pulse,
   output logic [8:0]              viol_sticky,
   output logic [CNT_WIDTH-1:0]    viol_count,
   output logic                    burst_active,
   output logic [4:0]              beat_cnt
);

   localparam int         WW     = $clog2(MAX_WAIT + 2);
   localparam logic [2:0] MAX_SZ = 3'($clog2(DATA_WIDTH / 8));
   localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);
   localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_ERR} state_t;

   state_t                  state_q, state_d;
   logic [HBURST_WIDTH-1:0] burst_q, burst_d;
   logic [2:0]              size_q, size_d;
   logic                    write_q, write_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [4:0]              beat_q, beat_d;
   logic                    pend_q, pend_d;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic [1:0]              ptrans_q, ptrans_d;
   logic                    err1_q, err1_d;
   logic [WW-1:0]           wait_q, wait_d;
   logic [8:0]              pulse_q, pulse_d;
   logic [8:0]              sticky_q, sticky_d;
   logic [CNT_WIDTH-1:0]    count_q, count_d;

   logic                  sel, acc, nseq, seq, idle_acc, in_burst;
   logic                  wrap, fixed, incr;
   logic [2:0]            bt;
   logic [4:0]            len;
   logic [ADDR_WIDTH-1:0] inc, bnd, msk, exp_addr;
   logic [8:0]            raw;

   // Decode the current transfer and the latched burst shape.
   always_comb begin
      sel      = |HSEL;
      acc      = HREADY & sel & HTRANS[1];
      nseq     = acc & ~HTRANS[0];
      seq      = acc & HTRANS[0];
      idle_acc = HREADY & sel & (HTRANS == 2'b00);
      in_burst = (state_q == ST_BURST);
      bt       = 3'(burst_q);
      wrap     = (bt != 3'd0) & ~bt[0];
      incr     = bt[0];
      fixed    = bt[2] | bt[1];
      len      = 5'd1 << ({1'b0, bt[2:1]} + 3'd1);
      inc      = ADDR_WIDTH'(1) << size_q;
      bnd      = inc << ({1'b0, bt[2:1]} + 3'd1);
      msk      = bnd - ADDR_WIDTH'(1);
      exp_addr = addr_q + inc;
      if (wrap)
         exp_addr = (addr_q & ~msk) | ((addr_q + inc) & msk);
   end

   // Per-check violation detection on this cycle's inputs.
   always_comb begin
      raw    = '0;
      raw[0] = (state_q == ST_IDLE) & HREADY & sel & HTRANS[0];
      raw[1] = seq & in_burst & (HADDR != exp_addr);
      raw[2] = seq & in_burst & ((HBURST != burst_q) |
               (HSIZE != size_q) | (HWRITE != write_q));
      raw[3] = pend_q & ~err1_q &
               ((HADDR != paddr_q) | (HTRANS != ptrans_q));
      raw[4] = (seq & fixed & (beat_q >= len)) |
               (in_burst & fixed & (nseq | idle_acc) & (beat_q < len));
      raw[5] = acc & (HSIZE > MAX_SZ);
      raw[6] = HRESP & HREADY & ~err1_q;
      raw[7] = ~HREADY & (wait_q == WAIT_LIM);
      raw[8] = seq & in_burst & incr &
               (HADDR[ADDR_WIDTH-1:10] != addr_q[ADDR_WIDTH-1:10]);
   end

   // Next-state for the burst FSM and tracking registers.
   always_comb begin
      state_d  = state_q;
      burst_d  = burst_q;
      size_d   = size_q;
      write_d  = write_q;
      addr_d   = addr_q;
      beat_d   = beat_q;
      pend_d   = ~HREADY & sel & HTRANS[1];
      paddr_d  = HADDR;
      ptrans_d = HTRANS;
      err1_d   = HRESP & ~HREADY;
      wait_d   = '0;
      if (!HREADY)
         wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + 1'b1;
      if (acc)
         addr_d = HADDR;
      if (nseq) begin
         burst_d = HBURST;
         size_d  = HSIZE;
         write_d = HWRITE;
         beat_d  = 5'd1;
      end else if (seq && in_burst && beat_q != 5'd31) begin
         beat_d = beat_q + 5'd1;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (nseq && HBURST != '0)
               state_d = ST_BURST;
         end
         ST_BURST: begin
            if (HRESP && !HREADY)
               state_d = ST_ERR;
            else if (nseq)
               state_d = (HBURST != '0) ? ST_BURST : ST_IDLE;
            else if (idle_acc)
               state_d = ST_IDLE;
            else if (seq && fixed && (beat_q + 5'd1 >= len))
               state_d = ST_IDLE;
         end
         ST_ERR: begin
            state_d = (nseq && HBURST != '0) ? ST_BURST : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reporting: masked pulse, sticky flags, saturating counter.
   always_comb begin
      pulse_d  = chk_en ? raw : '0;
      sticky_d = sticky_q | pulse_d;
      count_d  = count_q;
      if (pulse_d != '0 && count_q != '1)
         count_d = count_q + 1'b1;
      if (clr) begin
         sticky_d = '0;
         count_d  = '0;
      end
   end

   // State registers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= ST_IDLE;
         burst_q  <= '0;
         size_q   <= '0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         beat_q   <= '0;
         pend_q   <= 1'b0;
         paddr_q  <= '0;
         ptrans_q <= '0;
         err1_q   <= 1'b0;
         wait_q   <= '0;
         pulse_q  <= '0;
         sticky_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         burst_q  <= burst_d;
         size_q   <= size_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         beat_q   <= beat_d;
         pend_q   <= pend_d;
         paddr_q  <= paddr_d;
         ptrans_q <= ptrans_d;
         err1_q   <= err1_d;
         wait_q   <= wait_d;
         pulse_q  <= pulse_d;
         sticky_q <= sticky_d;
         count_q  <= count_d;
      end
   end

   assign viol_pulse   = pulse_q;
   assign viol_sticky  = sticky_q;
   assign viol_count   = count_q;
   assign burst_active = (state_q == ST_BURST);
   assign beat_cnt     = beat_q;

endmodule

// File: tb/tb_ahb5_protocol_checker.sv
// Directed bench for ahb5_protocol_checker.
// Linear stimulus with hand-computed expectations.
module tb_ahb5_protocol_checker;

   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_NSEQ = 2'd2;
   localparam logic [1:0] T_SEQ  = 2'd3;

   logic        HCLK;
   logic        HRESETn;
   logic [0:0]  HSEL;
   logic        HREADY;
   logic [31:0] HADDR;
   logic [2:0]  HBURST;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic        HRESP;
   logic        chk_en;
   logic        clr;
   logic [8:0]  viol_pulse;
   logic [8:0]  viol_sticky;
   logic [7:0]  viol_count;
   logic        burst_active;
   logic [4:0]  beat_cnt;

   int checks = 0;
   int errors = 0;
   int n7;

   ahb5_protocol_checker dut (
      .HCLK(HCLK),
      .HRESETn(HRESETn),
      .HSEL(HSEL),
      .HREADY(HREADY),
      .HADDR(HADDR),
      .HBURST(HBURST),
      .HSIZE(HSIZE),
      .HTRANS(HTRANS),
      .HWRITE(HWRITE),
      .HRESP(HRESP),
      .chk_en(chk_en),
      .clr(clr),
      .viol_pulse(viol_pulse),
      .viol_sticky(viol_sticky),
      .viol_count(viol_count),
      .burst_active(burst_active),
      .beat_cnt(beat_cnt)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic [1:0] tr, input logic [31:0] a,
                      input logic [2:0] b, input logic [2:0] s,
                      input logic w, input logic rdy, input logic rsp);
      HTRANS = tr;
      HADDR  = a;
      HBURST = b;
      HSIZE  = s;
      HWRITE = w;
      HREADY = rdy;
      HRESP  = rsp;
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pulse"}, 32'(viol_pulse), 0);
      chk({tag, "_sticky"}, 32'(viol_sticky), 0);
      chk({tag, "_count"}, 32'(viol_count), 0);
      chk({tag, "_active"}, 32'(burst_active), 0);
      chk({tag, "_beat"}, 32'(beat_cnt), 0);
   endtask

   initial begin
      HRESETn = 1'b0;
      HSEL    = 1'b1;
      HREADY  = 1'b1;
      HADDR   = '0;
      HBURST  = '0;
      HSIZE   = 3'd2;
      HTRANS  = T_IDLE;
      HWRITE  = 1'b0;
      HRESP   = 1'b0;
      chk_en  = 1'b1;
      clr     = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      chk_zero("reset");
      HRESETn = 1'b1;

      // SEQ straight after reset
      cyc(T_SEQ, 32'h0, 3'd0, 3'd2, 0, 1, 0);
      chk("seq_after_rst", 32'(viol_pulse), 32'h001);
      chk("seq_after_rst_cnt", 32'(viol_count), 1);
      cyc(T_IDLE, 32'h0, 3'd0, 3'd2, 0, 1, 0);
      chk("sticky_hold", 32'(viol_sticky), 32'h001);
      chk("pulse_clear", 32'(viol_pulse), 0);
      clr = 1'b1;
      cyc(T_IDLE, 32'h0, 3'd0, 3'd2, 0, 1, 0);
      clr = 1'b0;
      chk_zero("after_clr");

      // legal INCR4 from 0x100
      cyc(T_NSEQ, 32'h100, 3'd3, 3'd2, 0, 1, 0);
      chk("incr4_b1_active", 32'(burst_active), 1);
      chk("incr4_b1_beat", 32'(beat_cnt), 1);
      cyc(T_SEQ, 32'h104, 3'd3, 3'd2, 0, 1, 0);
      cyc(T_SEQ, 32'h108, 3'd3, 3'd2, 0, 1, 0);
      chk("incr4_b3_beat", 32'(beat_cnt), 3);
      chk("incr4_b3_active", 32'(burst_active), 1);
      cyc(T_SEQ, 32'h10C, 3'd3, 3'd2, 0, 1, 0);
      chk("incr4_b4_beat", 32'(beat_cnt), 4);
      chk("incr4_b4_active", 32'(burst_active), 0);
      cyc(T_IDLE, 32'h0, 3'd0, 3'd2, 0, 1, 0);
      chk("incr4_sticky", 32'(viol_sticky), 0);

      // legal WRAP4 from 0x38
      cyc(T_NSEQ, 32'h38, 3'd2, 3'd2, 0, 1, 0);
      cyc(T_SEQ, 32'h3C, 3'd2, 3'd2, 0, 1, 0);
      cyc(T_SEQ, 32'h30, 3'd2, 3'd2, 0, 1, 0);
      chk("wrap4_wrapped", 32'(viol_pulse), 0);
      cyc(T_SEQ, 32'h34, 3'd2, 3'd2, 0, 1, 0);
      chk("wrap4_last", 32'(viol_pulse), 0);
      chk("wrap4_done", 32'(burst_active), 0);
      chk("wrap4_sticky", 32'(viol_sticky), 0);

      // WRAP4 with a wrong wrap address
      cyc(T_NSEQ, 32'h38, 3'd2, 3'd2, 0, 1, 0);
      cyc(T_SEQ, 32'h3C, 3'd2, 3'd2, 0, 1, 0);
      cyc(T_SEQ, 32'h40, 3'd2, 3'd2, 0, 1, 0);
      chk("wrap4_badaddr", 32'(viol_pulse), 32'h002);
      chk("wrap4_badaddr_cnt", 32'(viol_count), 1);
      cyc(T_SEQ, 32'h44, 3'd2, 3'd2, 0, 1, 0);
      chk("wrap4_from_actual", 32'(viol_pulse), 0);
      chk("wrap4_bad_done", 32'(burst_active), 0);

      // single-cycle ERROR
      cyc(T_IDLE, 32'h0, 3'd0, 3'd2, 0, 1, 1);
      chk("err_1cyc", 32'(viol_pulse), 32'h040);
      chk("err_1cyc_cnt", 32'(viol_count), 2);
      cyc(T_IDLE, 32'h0, 3'd0, 3'd2, 0, 1, 0);

      // two-cycle ERROR then IDLE mid INCR8
      cyc(T_NSEQ, 32'h200, 3'd5, 3'd2, 0, 1, 0);
      cyc(T_SEQ, 32'h204, 3'd5, 3'd2, 0, 1, 0);
      cyc(T_SEQ, 32'h208, 3'd5, 3'd2, 0, 0, 1);
      chk("err2_c1", 32'(viol_pulse), 0);
      cyc(T_IDLE, 32'h208, 3'd5, 3'd2, 0, 1, 1);
      chk("err2_c2", 32'(viol_pulse), 0);
      cyc(T_IDLE, 32'h0, 3'd0, 3'd2, 0, 1, 0);
      chk("err2_after", 32'(viol_pulse), 0);
      chk("err2_cnt", 32'(viol_count), 2);

      // wait-state timeout fires once per stall
      n7 = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(T_IDLE, 32'h0, 3'd0, 3'd2, 0, 0, 0);
         if (viol_pulse[7]) n7++;
      end
      chk("stall_once", 32'(n7), 1);
      chk("stall_cnt", 32'(viol_count), 3);
      cyc(T_IDLE, 32'h0, 3'd0, 3'd2, 0, 1, 0);
      for (int i = 0; i < 17; i++) begin
         cyc(T_IDLE, 32'h0, 3'd0, 3'd2, 0, 0, 0);
         if (i == 15) chk("rearm_16", 32'(viol_pulse), 0);
         if (i == 16) chk("rearm_17", 32'(viol_pulse), 32'h080);
      end
      chk("rearm_cnt", 32'(viol_count), 4);
      cyc(T_IDLE, 32'h0, 3'd0, 3'd2, 0, 1, 0);

      // address changed while stalled
      cyc(T_NSEQ, 32'h300, 3'd0, 3'd2, 0, 0, 0);
      cyc(T_NSEQ, 32'h304, 3'd0, 3'd2, 0, 1, 0);
      chk("stall_addr_chg", 32'(viol_pulse), 32'h008);
      chk("single_beat", 32'(beat_cnt), 1);
      chk("single_idle", 32'(burst_active), 0);
      chk("stall_chg_cnt", 32'(viol_count), 5);

      // oversize HSIZE
      cyc(T_NSEQ, 32'h300, 3'd0, 3'd3, 0, 1, 0);
      chk("hsize_big", 32'(viol_pulse), 32'h020);

      // 1 KB crossing on INCR
      cyc(T_NSEQ, 32'h3FC, 3'd1, 3'd2, 0, 1, 0);
      cyc(T_SEQ, 32'h400, 3'd1, 3'd2, 0, 1, 0);
      chk("kb_cross", 32'(viol_pulse), 32'h100);
      cyc(T_IDLE, 32'h0, 3'd0, 3'd2, 0, 1, 0);
      chk("incr_idle_end", 32'(viol_pulse), 0);
      chk("kb_cnt", 32'(viol_count), 7);

      // chk_en low masks violations
      chk_en = 1'b0;
      cyc(T_SEQ, 32'h0, 3'd0, 3'd2, 0, 1, 0);
      chk("mask_pulse", 32'(viol_pulse), 0);
      chk("mask_cnt", 32'(viol_count), 7);
      chk_en = 1'b1;

      // early termination of INCR4
      cyc(T_NSEQ, 32'h500, 3'd3, 3'd2, 0, 1, 0);
      cyc(T_SEQ, 32'h504, 3'd3, 3'd2, 0, 1, 0);
      cyc(T_IDLE, 32'h0, 3'd0, 3'd2, 0, 1, 0);
      chk("early_term", 32'(viol_pulse), 32'h010);
      chk("early_cnt", 32'(viol_count), 8);
      chk("sticky_all", 32'(viol_sticky), 32'h1FA);

      // counter saturation
      for (int i = 0; i < 300; i++)
         cyc(T_SEQ, 32'h0, 3'd0, 3'd2, 0, 1, 0);
      chk("saturate", 32'(viol_count), 255);

      // clr wins over same-cycle increment
      clr = 1'b1;
      cyc(T_SEQ, 32'h0, 3'd0, 3'd2, 0, 1, 0);
      clr = 1'b0;
      chk("clr_pulse", 32'(viol_pulse), 32'h001);
      chk("clr_sticky", 32'(viol_sticky), 0);
      chk("clr_cnt", 32'(viol_count), 0);

      // asynchronous reset mid-burst
      cyc(T_NSEQ, 32'h600, 3'd5, 3'd2, 0, 1, 0);
      cyc(T_SEQ, 32'h604, 3'd5, 3'd2, 0, 1, 0);
      chk("pre_rst_active", 32'(burst_active), 1);
      chk("pre_rst_beat", 32'(beat_cnt), 2);
      #2;
      HRESETn = 1'b0;
      #1;
      chk_zero("async_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
